// File: rtl/fb_arbiter_if.sv
// Bus bundle between the framebuffer arbiter, its requesters and the framebuffer RAM.
// The arbiter owns the master side; the surrounding logic/RAM sees the slave side.
interface fb_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12
);
  logic              vsync_start;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              swap_req;
  logic              swap_ack;
  logic              front_buf;
  logic [7:0]        frame_cnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W:0]   mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  vsync_start, rd_req, rd_addr, wr_valid, wr_addr, wr_data, swap_req, mem_rdata,
    output rd_valid, rd_data, wr_ready, swap_ack, front_buf, frame_cnt,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output vsync_start, rd_req, rd_addr, wr_valid, wr_addr, wr_data, swap_req, mem_rdata,
    input  rd_valid, rd_data, wr_ready, swap_ack, front_buf, frame_cnt,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: scanout reads win over rasterizer writes,
// double-buffered with the front/back swap committed only on vsync_start.
module fb_arbiter #(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 12,
  parameter int MEM_LATENCY = 1
) (
  input  logic         clk_pix,
  input  logic         resetn,
  fb_arbiter_if.master bus
);

  typedef enum logic {
    RUN       = 1'b0,
    SWAP_PEND = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic   commit;
  logic   wr_ready_c;

  logic              mem_en_q, mem_we_q;
  logic [ADDR_W:0]   mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_en_nxt, mem_we_nxt;
  logic [ADDR_W:0]   mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;

  logic [MEM_LATENCY:0] rd_tag;
  logic                 rd_valid_q;
  logic [DATA_W-1:0]    rd_data_q;

  logic       front_q;
  logic       swap_ack_q;
  logic [7:0] frame_q;

  // Swap FSM
  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) state <= RUN;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    commit     = 1'b0;
    wr_ready_c = 1'b0;
    unique case (state)
      RUN: begin
        wr_ready_c = !bus.rd_req;
        // A vsync_start coinciding with swap_req is not consumed here.
        if (bus.swap_req) state_nxt = SWAP_PEND;
      end
      SWAP_PEND: begin
        if (bus.vsync_start) begin
          commit    = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Request arbitration: reads always win, so reads and writes are mutually exclusive.
  always_comb begin
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr_q;
    mem_wdata_nxt = mem_wdata_q;
    if (bus.rd_req) begin
      mem_en_nxt   = 1'b1;
      mem_addr_nxt = {front_q, bus.rd_addr};
    end else if (bus.wr_valid && wr_ready_c) begin
      mem_en_nxt    = 1'b1;
      mem_we_nxt    = 1'b1;
      mem_addr_nxt  = {~front_q, bus.wr_addr};
      mem_wdata_nxt = bus.wr_data;
    end
  end

  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_en_q    <= mem_en_nxt;
      mem_we_q    <= mem_we_nxt;
      mem_addr_q  <= mem_addr_nxt;
      mem_wdata_q <= mem_wdata_nxt;
    end
  end

  // Tag bit MEM_LATENCY lines up with the cycle mem_rdata is valid for that read.
  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      rd_tag     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_tag     <= {rd_tag[MEM_LATENCY-1:0], bus.rd_req};
      rd_valid_q <= rd_tag[MEM_LATENCY];
      if (rd_tag[MEM_LATENCY]) rd_data_q <= bus.mem_rdata;
    end
  end

  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      front_q    <= 1'b0;
      swap_ack_q <= 1'b0;
      frame_q    <= '0;
    end else begin
      swap_ack_q <= commit;
      if (commit) begin
        front_q <= ~front_q;
        frame_q <= frame_q + 8'd1;
      end
    end
  end

  assign bus.wr_ready  = wr_ready_c;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.swap_ack  = swap_ack_q;
  assign bus.front_buf = front_q;
  assign bus.frame_cnt = frame_q;

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between two requesters: VGA scanout reads, which have fixed top priority, and rasterizer pixel writes, which use a valid/ready handshake.
- Manages double buffering. Scanout reads the front buffer and the rasterizer writes the back buffer.
- A buffer swap is requested by the rasterizer and committed only at vertical sync, so there is no tearing.
- Sits between signal_480p60/rasterizer/shader and the framebuffer RAM in the clk_pix domain.

Parameters:
- ADDR_W, 19, pixel address width per buffer (640x480 = 307200 pixels).
- DATA_W, 12, pixel width (4-bit R, G, B).
- MEM_LATENCY, 1, RAM read latency in cycles from the sampled request to valid mem_rdata (range 1 to 4).

Ports:
- clk_pix  in  1  pixel clock; the only clock.
- resetn  in  1  asynchronous, active-low reset.
- vsync_start  in  1  one-cycle pulse on the first cycle of vertical sync.
- rd_req  in  1  scanout read request; always served in the same cycle.
- rd_addr  in  ADDR_W  scanout pixel address.
- rd_valid  out  1  rd_data is valid this cycle.
- rd_data  out  DATA_W  read pixel.
- wr_valid  in  1  rasterizer write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_addr  in  ADDR_W  write pixel address.
- wr_data  in  DATA_W  write pixel.
- swap_req  in  1  one-cycle pulse: back buffer complete.
- swap_ack  out  1  one-cycle pulse: swap committed.
- front_buf  out  1  index of the buffer being scanned out.
- frame_cnt  out  8  count of committed swaps.
- mem_en  out  1  RAM enable (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_addr  out  ADDR_W+1  RAM address, {buffer, pixel} (registered).
- mem_wdata  out  DATA_W  RAM write data (registered).
- mem_rdata  in  DATA_W  RAM read data.

Behaviour:
- Reset (asynchronous, resetn low):
  - Outputs: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_valid=0, rd_data=0, swap_ack=0, front_buf=0, frame_cnt=0.
  - State goes to RUN and the read-tag pipeline is cleared.
  - Reads in flight when reset asserts never produce rd_valid.
- Arbitration, evaluated combinationally each cycle:
  - wr_ready = !rd_req && state==RUN.
  - If rd_req: next mem_en=1, mem_we=0, mem_addr={front_buf, rd_addr}.
  - Else if wr_valid && wr_ready: next mem_en=1, mem_we=1, mem_addr={~front_buf, wr_addr}, mem_wdata=wr_data.
  - Otherwise: next mem_en=0, mem_we=0. mem_addr and mem_wdata hold their values.
- Read latency:
  - A read tag enters a shift register of depth MEM_LATENCY+1.
  - rd_valid is asserted exactly MEM_LATENCY+2 cycles after the rd_req cycle.
  - rd_data is registered from mem_rdata in the same cycle rd_valid is asserted.
  - Back-to-back reads sustain 1 pixel per cycle with order preserved.
  - rd_data holds its value when rd_valid=0.
- Swap FSM, two states:
  - RUN: a swap_req pulse moves to SWAP_PEND.
  - SWAP_PEND:
    - wr_ready=0, because the back buffer is frozen.
    - Further swap_req pulses are ignored.
    - On vsync_start: front_buf toggles at that clock edge, swap_ack=1 for one cycle, frame_cnt increments (wraps 255 to 0), and the FSM returns to RUN.
- Simultaneous events:
  - swap_req && vsync_start while in RUN: enter SWAP_PEND; this vsync_start is not consumed, so the commit happens on the next vsync_start.
  - A read issued in the vsync_start commit cycle uses the old front_buf. Reads already in the pipeline complete unchanged.
  - A write pending while rd_req is high stalls with no loss. wr_addr and wr_data must be held by the source, per standard valid/ready rules.
- The arbiter never drives mem_en with both a read and a write in the same cycle.

Test Plan:
- Reset then a read: rd_req=1, rd_addr=5, with mem model returning 12'hABC → mem_addr=20'h00005 one cycle later; rd_valid=1 with rd_data=12'hABC 3 cycles after the request; a 4-cycle read burst yields 4 consecutive rd_valid cycles in order.
- Conflict: wr_valid=1 (addr 7, data 12'h123) while rd_req is high for 3 cycles → wr_ready=0 for those 3 cycles; the write issues on the first cycle rd_req=0 with mem_addr=20'h80007, mem_we=1, mem_wdata=12'h123.
- Swap: swap_req pulse, then writes offered → wr_ready=0; vsync_start 100 cycles later → front_buf 0→1, swap_ack is a single pulse, frame_cnt=1, wr_ready returns to 1, and writes go to mem_addr[19]=0.
- Simultaneous swap_req and vsync_start in RUN → no swap on that edge; the next vsync_start commits, front_buf toggles, and swap_ack pulses once.
- frame_cnt wrap: 256 commit sequences → frame_cnt reads 0 and front_buf ends at 0.
- Reset mid-burst: resetn low one cycle after 2 reads → no rd_valid ever appears, all outputs return to reset values, and state is RUN.
